// File: rtl/axi_req_sched.sv
// Single-grant scheduler between the cache/uncached miss sources and the AXI
// bridge request interface; holds one request until its reload, then pulses done.
module axi_req_sched #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_miss,
    input  logic [31:0]  i_miss_addr,
    output logic         i_done,
    input  logic         d_miss,
    input  logic [31:0]  d_miss_addr,
    input  logic         d_dirty,
    input  logic [31:0]  d_wb_addr,
    input  logic [255:0] d_wb_line,
    output logic         d_done,
    input  logic         u_rd,
    input  logic         u_wr,
    input  logic [31:0]  u_addr,
    input  logic [3:0]   u_wstrb,
    input  logic [31:0]  u_wdata,
    output logic         u_done,
    output logic         ird_req,
    output logic         drd_req,
    output logic         dwr_req,
    output logic         unrd_req,
    output logic         unwr_req,
    output logic [31:0]  ird_addr,
    output logic [31:0]  drd_addr,
    output logic [31:0]  dwr_addr,
    output logic [31:0]  unrd_addr,
    output logic [31:0]  unwr_addr,
    output logic [255:0] dcacheline_old,
    output logic [3:0]   unwr_wstrb,
    output logic [31:0]  unwr_data,
    input  logic         i_reload,
    input  logic         d_reload,
    input  logic         un_reload,
    output logic         busy,
    output logic [1:0]   grant,
    output logic         timeout_err
);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [15:0] TMO_LIM    = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  win;
    logic        done_hit;
    logic [3:0]  starve_q, starve_inc;
    logic [15:0] tmo_q, tmo_inc;

    always_comb begin
        state_d = state_q;
        win     = 2'd0;
        // icache starvation guard overrides the fixed uncached > dcache > icache order
        if (i_miss && (starve_q >= STARVE_LIM)) win = 2'd1;
        else if (u_rd || u_wr)                  win = 2'd3;
        else if (d_miss)                        win = 2'd2;
        else if (i_miss)                        win = 2'd1;
        done_hit   = ((grant == 2'd1) && i_reload) ||
                     ((grant == 2'd2) && d_reload) ||
                     ((grant == 2'd3) && un_reload);
        tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + 16'd1;
        starve_inc = (starve_q == '1) ? starve_q : starve_q + 4'd1;
        case (state_q)
            IDLE:    if (win != 2'd0) state_d = WAIT;
            WAIT:    if (done_hit) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            tmo_q          <= '0;
            timeout_err    <= 1'b0;
            grant          <= '0;
            i_done         <= 1'b0;
            d_done         <= 1'b0;
            u_done         <= 1'b0;
            ird_req        <= 1'b0;
            drd_req        <= 1'b0;
            dwr_req        <= 1'b0;
            unrd_req       <= 1'b0;
            unwr_req       <= 1'b0;
            ird_addr       <= '0;
            drd_addr       <= '0;
            dwr_addr       <= '0;
            unrd_addr      <= '0;
            unwr_addr      <= '0;
            dcacheline_old <= '0;
            unwr_wstrb     <= '0;
            unwr_data      <= '0;
        end else begin
            state_q <= state_d;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            u_done  <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    grant <= win;
                    case (win)
                        2'd1: begin
                            ird_req  <= 1'b1;
                            ird_addr <= i_miss_addr;
                            starve_q <= '0;
                        end
                        2'd2: begin
                            drd_req        <= 1'b1;
                            drd_addr       <= d_miss_addr;
                            dwr_req        <= d_dirty;
                            dwr_addr       <= d_wb_addr;
                            dcacheline_old <= d_wb_line;
                            starve_q       <= i_miss ? starve_inc : '0;
                        end
                        2'd3: begin
                            // write wins when both are raised; the read stays pending
                            unwr_req <= u_wr;
                            unrd_req <= ~u_wr;
                            if (u_wr) begin
                                unwr_addr  <= u_addr;
                                unwr_wstrb <= u_wstrb;
                                unwr_data  <= u_wdata;
                            end else begin
                                unrd_addr <= u_addr;
                            end
                            starve_q <= i_miss ? starve_inc : '0;
                        end
                        default: ;
                    endcase
                end
                WAIT: begin
                    tmo_q <= tmo_inc;
                    if (tmo_inc >= TMO_LIM) timeout_err <= 1'b1;
                    if (done_hit) begin
                        ird_req  <= 1'b0;
                        drd_req  <= 1'b0;
                        dwr_req  <= 1'b0;
                        unrd_req <= 1'b0;
                        unwr_req <= 1'b0;
                        grant    <= '0;
                        i_done   <= (grant == 2'd1);
                        d_done   <= (grant == 2'd2);
                        u_done   <= (grant == 2'd3);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_req_sched.sv
// Randomized bench for axi_req_sched: transaction-level reference model plus
// directed scenarios with literal expectations.
module tb_axi_req_sched;
    localparam int SL  = 4;
    localparam int TMO = 1024;

    logic         clk, rst;
    logic         i_miss, d_miss, d_dirty, u_rd, u_wr;
    logic [31:0]  i_miss_addr, d_miss_addr, d_wb_addr, u_addr, u_wdata;
    logic [255:0] d_wb_line;
    logic [3:0]   u_wstrb;
    logic         i_reload, d_reload, un_reload;
    logic         i_done, d_done, u_done;
    logic         ird_req, drd_req, dwr_req, unrd_req, unwr_req;
    logic [31:0]  ird_addr, drd_addr, dwr_addr, unrd_addr, unwr_addr, unwr_data;
    logic [255:0] dcacheline_old;
    logic [3:0]   unwr_wstrb;
    logic         busy, timeout_err;
    logic [1:0]   grant;

    axi_req_sched #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr), .i_done(i_done),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr), .d_dirty(d_dirty),
        .d_wb_addr(d_wb_addr), .d_wb_line(d_wb_line), .d_done(d_done),
        .u_rd(u_rd), .u_wr(u_wr), .u_addr(u_addr), .u_wstrb(u_wstrb),
        .u_wdata(u_wdata), .u_done(u_done),
        .ird_req(ird_req), .drd_req(drd_req), .dwr_req(dwr_req),
        .unrd_req(unrd_req), .unwr_req(unwr_req),
        .ird_addr(ird_addr), .drd_addr(drd_addr), .dwr_addr(dwr_addr),
        .unrd_addr(unrd_addr), .unwr_addr(unwr_addr),
        .dcacheline_old(dcacheline_old), .unwr_wstrb(unwr_wstrb), .unwr_data(unwr_data),
        .i_reload(i_reload), .d_reload(d_reload), .un_reload(un_reload),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: owner of the outstanding transaction (0 = none) and the
    // owner whose done pulse is currently showing.
    logic [1:0]   m_owner, m_done;
    int           m_starve, m_wait;
    logic         m_terr, m_dirty, m_uwr;
    logic [31:0]  m_iaddr, m_daddr, m_waddr, m_uaddr, m_wdata;
    logic [255:0] m_line;
    logic [3:0]   m_wstrb;

    function automatic logic [1:0] pick();
        if (i_miss && m_starve >= SL) return 2'd1;
        if (u_rd || u_wr) return 2'd3;
        if (d_miss) return 2'd2;
        if (i_miss) return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 0; m_done <= 0; m_starve <= 0; m_wait <= 0; m_terr <= 0;
            m_dirty <= 0; m_uwr <= 0;
        end else begin
            m_done <= 0;
            if (m_done != 0) begin
                // one-cycle turnaround before new requests are considered
            end else if (m_owner != 0) begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= TMO) m_terr <= 1;
                if ((m_owner == 1 && i_reload) || (m_owner == 2 && d_reload) ||
                    (m_owner == 3 && un_reload)) begin
                    m_done  <= m_owner;
                    m_owner <= 0;
                end
            end else begin
                m_owner <= pick();
                m_wait  <= 0;
                case (pick())
                    2'd1: begin m_iaddr <= i_miss_addr; m_starve <= 0; end
                    2'd2: begin
                        m_daddr <= d_miss_addr; m_dirty <= d_dirty;
                        m_waddr <= d_wb_addr; m_line <= d_wb_line;
                        m_starve <= i_miss ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
                    end
                    2'd3: begin
                        m_uwr <= u_wr; m_uaddr <= u_addr; m_wstrb <= u_wstrb; m_wdata <= u_wdata;
                        m_starve <= i_miss ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("grant", 256'(grant), 256'(m_owner));
            chk("busy", 256'(busy), 256'((m_owner != 0) || (m_done != 0)));
            chk("ird_req", 256'(ird_req), 256'(m_owner == 1));
            chk("drd_req", 256'(drd_req), 256'(m_owner == 2));
            chk("dwr_req", 256'(dwr_req), 256'(m_owner == 2 && m_dirty));
            chk("unwr_req", 256'(unwr_req), 256'(m_owner == 3 && m_uwr));
            chk("unrd_req", 256'(unrd_req), 256'(m_owner == 3 && !m_uwr));
            chk("i_done", 256'(i_done), 256'(m_done == 1));
            chk("d_done", 256'(d_done), 256'(m_done == 2));
            chk("u_done", 256'(u_done), 256'(m_done == 3));
            chk("timeout_err", 256'(timeout_err), 256'(m_terr));
            if (m_owner == 1) chk("ird_addr", 256'(ird_addr), 256'(m_iaddr));
            if (m_owner == 2) begin
                chk("drd_addr", 256'(drd_addr), 256'(m_daddr));
                if (m_dirty) begin
                    chk("dwr_addr", 256'(dwr_addr), 256'(m_waddr));
                    chk("dcacheline_old", dcacheline_old, m_line);
                end
            end
            if (m_owner == 3) begin
                if (m_uwr) begin
                    chk("unwr_addr", 256'(unwr_addr), 256'(m_uaddr));
                    chk("unwr_wstrb", 256'(unwr_wstrb), 256'(m_wstrb));
                    chk("unwr_data", 256'(unwr_data), 256'(m_wdata));
                end else begin
                    chk("unrd_addr", 256'(unrd_addr), 256'(m_uaddr));
                end
            end
        end
    end

    // Stimulus agents: sources drop after done, bridge answers the owner.
    bit rand_en = 0, noise = 0, b_hold = 0, d_keep = 0;
    int b_fixed = 0, b_cnt = 0;

    task automatic step();
        bit di, dd, du;
        int r;
        @(negedge clk);
        i_reload = 0; d_reload = 0; un_reload = 0;
        di = 0; dd = 0; du = 0;
        if (m_done == 1) begin i_miss = 0; di = 1; end
        if (m_done == 2) begin d_miss = 0; dd = 1; end
        if (m_done == 3) begin
            if (u_wr) u_wr = 0; else u_rd = 0;
            du = 1;
        end
        if (m_owner != 0 && !b_hold) begin
            if (b_cnt == 0) begin
                case (m_owner)
                    2'd1: i_reload = 1;
                    2'd2: d_reload = 1;
                    default: un_reload = 1;
                endcase
                b_cnt = (b_fixed != 0) ? b_fixed : $urandom_range(0, 6);
            end else b_cnt--;
        end
        if (noise && $urandom_range(0, 7) == 0) begin
            r = $urandom_range(1, 3);
            if (r != int'(m_owner)) begin
                if (r == 1) i_reload = 1; else if (r == 2) d_reload = 1; else un_reload = 1;
            end
        end
        if (d_keep && !d_miss && !dd) d_miss = 1;
        if (rand_en) begin
            if (!i_miss && !di && $urandom_range(0, 3) == 0) begin
                i_miss = 1; i_miss_addr = $urandom;
            end
            if (!d_miss && !dd && $urandom_range(0, 3) == 0) begin
                d_miss = 1; d_miss_addr = $urandom; d_dirty = 1'($urandom_range(0, 1));
                d_wb_addr = $urandom; d_wb_line = {$urandom, $urandom, $urandom, $urandom,
                                                   $urandom, $urandom, $urandom, $urandom};
            end
            if (!u_rd && !u_wr && !du && $urandom_range(0, 4) == 0) begin
                r = $urandom_range(0, 2);
                u_rd = (r != 1); u_wr = (r != 0);
                u_addr = $urandom; u_wstrb = 4'($urandom_range(0, 15)); u_wdata = $urandom;
            end
            // inputs wiggling while a grant is held must not reach the bridge
            if ($urandom_range(0, 5) == 0) begin
                d_wb_line[31:0] = $urandom; d_dirty = 1'($urandom_range(0, 1));
                i_miss_addr = $urandom; u_wdata = $urandom; u_addr = $urandom;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(m_owner == 0 && m_done == 0 && !i_miss && !d_miss && !u_rd && !u_wr) && n < budget) begin
            step();
            n++;
        end
        chk(name, 256'(n < budget), 256'(1));
    endtask

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int nreq, ndone, ng;
    logic [1:0] pg;
    logic [1:0] gl [5];
    logic [1:0] exp_g [5];
    bit seen_rd;

    initial begin
        exp_g = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        rst = 1;
        i_miss = 0; d_miss = 0; d_dirty = 0; u_rd = 0; u_wr = 0;
        i_miss_addr = 0; d_miss_addr = 0; d_wb_addr = 0; d_wb_line = '0;
        u_addr = 0; u_wstrb = 0; u_wdata = 0;
        i_reload = 0; d_reload = 0; un_reload = 0;
        #12;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_grant", 256'(grant), 256'(0));
        chk("rst_reqs", 256'({ird_req, drd_req, dwr_req, unrd_req, unwr_req}), 256'(0));
        chk("rst_err", 256'(timeout_err), 256'(0));
        chk_on = 1;
        step(); rst = 0;
        repeat (2) step();

        // icache fill, reload 5 cycles after request
        b_fixed = 5; b_cnt = 5;
        i_miss = 1; i_miss_addr = 32'h1FC0_0040;
        step();
        chk("t1_ird_req", 256'(ird_req), 256'(1));
        chk("t1_ird_addr", 256'(ird_addr), 256'(32'h1FC0_0040));
        chk("t1_grant", 256'(grant), 256'(1));
        nreq = 1; ndone = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ird_req) nreq++;
            if (i_done) ndone++;
        end
        chk("t1_req_cycles", 256'(nreq), 256'(6));
        chk("t1_done_pulses", 256'(ndone), 256'(1));
        chk("t1_busy_after", 256'(busy), 256'(0));

        // dirty dcache miss with stray i_reload in WAIT
        d_miss = 1; d_dirty = 1; d_miss_addr = 32'h8000_0100; d_wb_addr = 32'h8000_2100;
        d_wb_line = {32{8'hA5}}; b_cnt = 5;
        step();
        chk("t2_drd_req", 256'(drd_req), 256'(1));
        chk("t2_dwr_req", 256'(dwr_req), 256'(1));
        chk("t2_line", dcacheline_old, {32{8'hA5}});
        chk("t2_dwr_addr", 256'(dwr_addr), 256'(32'h8000_2100));
        step(); i_reload = 1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (d_done) ndone++;
        end
        chk("t2_done_pulses", 256'(ndone), 256'(1));
        d_dirty = 0;

        // simultaneous uncached read+write: write first, read later
        u_rd = 1; u_wr = 1; u_addr = 32'hBFAF_F000; u_wstrb = 4'b0011; u_wdata = 32'h1234_5678;
        b_cnt = 2;
        step();
        chk("t3_unwr_req", 256'(unwr_req), 256'(1));
        chk("t3_unrd_req", 256'(unrd_req), 256'(0));
        chk("t3_wstrb", 256'(unwr_wstrb), 256'(4'b0011));
        ndone = 0; seen_rd = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (u_done) ndone++;
            if (unrd_req && !seen_rd) begin
                seen_rd = 1;
                chk("t3_unrd_addr", 256'(unrd_addr), 256'(32'hBFAF_F000));
            end
        end
        chk("t3_rd_issued", 256'(seen_rd), 256'(1));
        chk("t3_done_pulses", 256'(ndone), 256'(2));

        // starvation guard: four dcache grants, then icache
        b_fixed = 1; b_cnt = 1;
        i_miss = 1; i_miss_addr = 32'h0000_1000; d_miss = 1; d_keep = 1;
        ng = 0; pg = 0;
        for (int k = 0; k < 300 && ng < 5; k++) begin
            step();
            if (grant != 0 && pg == 0) begin gl[ng] = grant; ng++; end
            pg = grant;
        end
        d_keep = 0;
        for (int k = 0; k < 5; k++) chk($sformatf("t4_grant%0d", k), 256'(gl[k]), 256'(exp_g[k]));
        wait_idle("t4_idle", 100);

        // random traffic
        b_fixed = 0; rand_en = 1; noise = 1;
        repeat (3000) step();
        rand_en = 0; noise = 0;
        wait_idle("rand_idle", 300);

        // timeout: no reload for TIMEOUT WAIT cycles
        b_hold = 1;
        step(); i_miss = 1; i_miss_addr = 32'h0000_2000;
        step();
        chk("t5_ird_req", 256'(ird_req), 256'(1));
        repeat (TMO - 1) step();
        chk("t5_err_before", 256'(timeout_err), 256'(0));
        step();
        chk("t5_err_set", 256'(timeout_err), 256'(1));
        b_hold = 0; b_cnt = 3;
        wait_idle("t5_idle", 50);
        chk("t5_err_sticky", 256'(timeout_err), 256'(1));

        // async reset mid-WAIT
        b_hold = 1;
        step(); d_miss = 1; d_dirty = 1; d_miss_addr = 32'h8000_0200; d_wb_line = {32{8'h3C}};
        step(); step();
        #2 rst = 1; i_miss = 0; d_miss = 0; u_rd = 0; u_wr = 0;
        #1;
        chk("t6_drd_req", 256'(drd_req), 256'(0));
        chk("t6_busy", 256'(busy), 256'(0));
        chk("t6_grant", 256'(grant), 256'(0));
        chk("t6_line", dcacheline_old, 256'(0));
        chk("t6_err", 256'(timeout_err), 256'(0));
        step(); rst = 0; b_hold = 0;
        repeat (5) step();
        chk("t6_idle_busy", 256'(busy), 256'(0));
        chk("t6_idle_grant", 256'(grant), 256'(0));

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_req_sched.md
Name: axi_req_sched

Overview:
- Single-grant scheduler between the cache/uncached miss sources and the AXI bridge controller's request interface (ird/drd/dwr/unrd/unwr req/addr in, i/d/un_reload back).
- Captures one upstream request, drives the matching bridge request lines stably until the bridge's reload pulse, then returns a one-cycle done to the owner.
- Arbitrates uncached > dcache > icache, with a starvation guard for icache.
- Line and read data bypass this block (wired bridge -> caches directly).

Parameters:
STARVE_LIMIT, 4, consecutive data-side grants allowed while i_miss is pending before icache is forced next (range 1..15)
TIMEOUT, 1024, cycles in WAIT before timeout_err is set (counter width 16, saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_miss  in  1  icache line fill request (level, held until i_done)
i_miss_addr  in  32  icache line address
i_done  out  1  one-cycle pulse: icache fill complete
d_miss  in  1  dcache line fill request (level)
d_miss_addr  in  32  dcache fill address
d_dirty  in  1  victim dirty; write back in the same grant
d_wb_addr  in  32  victim address
d_wb_line  in  256  victim line
d_done  out  1  one-cycle pulse: dcache writeback+fill complete
u_rd  in  1  uncached read request (level)
u_wr  in  1  uncached write request (level)
u_addr  in  32  uncached address
u_wstrb  in  4  uncached byte strobes
u_wdata  in  32  uncached write data
u_done  out  1  one-cycle pulse: uncached access complete
ird_req, drd_req, dwr_req, unrd_req, unwr_req  out  1 each  bridge request lines
ird_addr, drd_addr, dwr_addr, unrd_addr, unwr_addr  out  32 each  bridge addresses
dcacheline_old  out  256  captured victim line
unwr_wstrb  out  4  captured strobes
unwr_data  out  32  captured write data
i_reload, d_reload, un_reload  in  1 each  bridge completion pulses
busy  out  1  high in any state other than IDLE
grant  out  2  current owner: 0 none, 1 icache, 2 dcache, 3 uncached
timeout_err  out  1  sticky WAIT timeout flag

Behaviour:
- Reset (async, immediate): all outputs 0, including every req, addr, dcacheline_old, unwr_*, done, busy, grant, timeout_err; FSM -> IDLE; starve counter and timeout counter 0.
- FSM states: IDLE, WAIT, GAP.
- IDLE: pick a winner among the pending requests.
  - Order: uncached (u_wr or u_rd) > dcache > icache.
  - Exception: if i_miss is pending and starve_cnt >= STARVE_LIMIT, icache wins.
  - On a win: capture addr/data into output regs, assert the bridge req lines (registered), set grant, go to WAIT. No pending request: stay in IDLE.
  - Request-to-bridge latency is 1 cycle.
- Line mapping:
  - icache: ird_req.
  - dcache: drd_req, plus dwr_req when d_dirty is set.
  - uncached: unwr_req if u_wr, else unrd_req. u_rd and u_wr together: write wins; u_rd is served on a later grant.
- starve_cnt:
  - Reset to 0 on any icache grant, or on a data-side grant while i_miss is low.
  - Increment (saturating at 15) on a data-side grant while i_miss is high.
- WAIT:
  - Hold every req/addr/data output constant; upstream input changes are ignored.
  - Completion is the reload matching grant (i_reload for 1, d_reload for 2, un_reload for 3). Non-matching reloads are ignored.
  - On completion: deassert all req lines and pulse the owner's done in the same registered update (both visible next cycle), then go to GAP.
  - Deasserting requests promptly is mandatory: the bridge resamples requests two cycles after its reload.
- timeout_cnt:
  - Counts WAIT cycles and clears on WAIT entry.
  - Reaching TIMEOUT sets timeout_err (sticky until rst); FSM keeps waiting.
- GAP: exactly one cycle with all reqs low and done high; grant returns to 0; then IDLE.
  - The owner must drop its request in the cycle after done. A request still high in IDLE is treated as a new request.
- Minimum turnaround: reload -> next bridge req = 3 cycles.
- Reset mid-WAIT: everything clears; the bridge shares the reset event, so no stale completion is expected. A reload arriving in IDLE/GAP is ignored.

Test Plan:
- i_miss=1, addr 0x1FC0_0040; i_reload 5 cycles after ird_req -> ird_req high from cycle 1 until reload+1, ird_addr=0x1FC0_0040, i_done single pulse, grant 1->0, busy low after GAP.
- d_miss+d_dirty, fill 0x8000_0100, victim 0x8000_2100, line 0xA5..A5 -> drd_req and dwr_req rise together, dcacheline_old=0xA5..A5, d_done only on d_reload; an i_reload injected mid-WAIT is ignored.
- u_rd and u_wr together at 0xBFAF_F000, wstrb 4'b0011 -> unwr_req first with unwr_wstrb=0011; after u_done and u_wr drop, unrd_req is issued.
- i_miss held high with dcache misses re-asserted back-to-back, STARVE_LIMIT=4 -> exactly 4 dcache grants, then an icache grant, then starve_cnt=0.
- No reload for 1024 WAIT cycles -> timeout_err=1 on the next cycle and stays set; a later reload still completes normally.
- rst pulsed asynchronously mid-WAIT (between clock edges) -> all outputs 0 immediately; after release with no requests pending, stays in IDLE.
